counter_sequencer: RTL and testbench

//  Shares one WIDTH-bit up/down counter among NREQ requesters. Each requester asks for a timed run
//  (direction + limit). A round-robin arbiter grants one run at a time, loads the counter, steps it

---
 rtl/counter_seq_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/counter_sequencer.sv | 132 +++++++++++++
 tb/tb_counter_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
// Shared constants and state encoding for the counter sequencer slice.
package counter_seq_pkg;

   localparam int unsigned NREQ_DEF  = 4;
   localparam int unsigned WIDTH_DEF = 4;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t RUN  = 2'd1;
   localparam state_t DONE = 2'd2;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from (last+1) mod NREQ for the first request.
module rr_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic [NREQ-1:0] win,
   output logic [IW-1:0]   win_idx,
   output logic            any
);

   int   idx;
   logic found;

   always_comb begin
      win     = '0;
      win_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 1; k <= int'(NREQ); k++) begin
         idx = (int'(last) + k) % int'(NREQ);
         if (!found && req[idx]) begin
            win[idx] = 1'b1;
            win_idx  = IW'(idx);
            found    = 1'b1;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/counter_sequencer.sv
// Shares one up/down counter among NREQ requesters; round-robin grant, timed run, done pulse.
module counter_sequencer
   import counter_seq_pkg::*;
#(
   parameter int unsigned NREQ  = NREQ_DEF,
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ-1:0]       up_dn,
   input  logic [NREQ*WIDTH-1:0] limit,
   output logic [NREQ-1:0]       grant,
   output logic                  busy,
   output logic [WIDTH-1:0]      count,
   output logic [NREQ-1:0]       done
);

   localparam int unsigned IW = $clog2(NREQ);

   state_t            state_q, state_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic [NREQ-1:0]   done_q, done_d;
   logic              busy_q, busy_d;
   logic [WIDTH-1:0]  count_q, count_d;
   logic              dir_q, dir_d;
   logic [WIDTH-1:0]  lim_q, lim_d;
   logic [IW-1:0]     oidx_q, oidx_d;
   logic [IW-1:0]     last_q, last_d;

   logic [NREQ-1:0]   arb_win;
   logic [IW-1:0]     arb_idx;
   logic              arb_any;
   logic [WIDTH-1:0]  lim_sel;
   logic [WIDTH-1:0]  terminal;

   rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_arb (
      .req     (req),
      .last    (last_q),
      .win     (arb_win),
      .win_idx (arb_idx),
      .any     (arb_any)
   );

   assign lim_sel  = limit[arb_idx*WIDTH +: WIDTH];
   assign terminal = (dir_q == DIR_UP) ? lim_q : '0;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      done_d  = '0;
      busy_d  = busy_q;
      count_d = count_q;
      dir_d   = dir_q;
      lim_d   = lim_q;
      oidx_d  = oidx_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (arb_any) begin
               state_d = RUN;
               grant_d = arb_win;
               busy_d  = 1'b1;
               oidx_d  = arb_idx;
               dir_d   = up_dn[arb_idx];
               lim_d   = lim_sel;
               count_d = (up_dn[arb_idx] == DIR_UP) ? '0 : lim_sel;
            end
         end
         RUN: begin
            // Abort wins over completion; the pointer still advances past the owner.
            if (!req[oidx_q]) begin
               state_d = IDLE;
               grant_d = '0;
               busy_d  = 1'b0;
               last_d  = oidx_q;
            end else if (count_q == terminal) begin
               state_d = DONE;
               done_d  = grant_q;
            end else if (dir_q == DIR_UP) begin
               count_d = count_q + WIDTH'(1);
            end else begin
               count_d = count_q - WIDTH'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
            last_d  = oidx_q;
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
         count_q <= '0;
         dir_q   <= DIR_UP;
         lim_q   <= '0;
         oidx_q  <= '0;
         last_q  <= IW'(NREQ - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         count_q <= count_d;
         dir_q   <= dir_d;
         lim_q   <= lim_d;
         oidx_q  <= oidx_d;
         last_q  <= last_d;
      end
   end

   assign grant = grant_q;
   assign done  = done_q;
   assign busy  = busy_q;
   assign count = count_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench: directed vector table, corner sequences, and random traffic vs a run model.
module tb_counter_sequencer;

   localparam int NREQ  = 4;
   localparam int WIDTH = 4;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NREQ-1:0]       req;
   logic [NREQ-1:0]       up_dn;
   logic [NREQ*WIDTH-1:0] limit;
   logic [NREQ-1:0]       grant;
   logic                  busy;
   logic [WIDTH-1:0]      count;
   logic [NREQ-1:0]       done;

   always #5 clk = ~clk;

   counter_sequencer #(
      .NREQ  (NREQ),
      .WIDTH (WIDTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .up_dn (up_dn),
      .limit (limit),
      .grant (grant),
      .busy  (busy),
      .count (count),
      .done  (done)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
   endtask

   // Run-level model: a granted run is the list of counter values it will show.
   int m_owner, m_last, m_count, m_pos;
   bit m_done;
   int m_seq[$];

   function automatic void model_reset();
      m_owner = -1;
      m_last  = NREQ - 1;
      m_count = 0;
      m_done  = 1'b0;
      m_pos   = 0;
      m_seq.delete();
   endfunction

   function automatic void model_step();
      int w;
      int lim;
      if (m_owner < 0) begin
         if (req != '0) begin
            w = -1;
            for (int k = 1; k <= NREQ; k++)
               if (w < 0 && req[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
            lim = int'(limit[w*WIDTH +: WIDTH]);
            m_seq.delete();
            for (int v = 0; v <= lim; v++) m_seq.push_back(up_dn[w] ? v : lim - v);
            m_owner = w;
            m_pos   = 0;
            m_count = m_seq[0];
            m_done  = 1'b0;
         end
      end else if (m_done) begin
         m_last  = m_owner;
         m_owner = -1;
         m_done  = 1'b0;
      end else if (!req[m_owner]) begin
         m_last  = m_owner;
         m_owner = -1;
      end else if (m_pos == m_seq.size() - 1) begin
         m_done = 1'b1;
      end else begin
         m_pos++;
         m_count = m_seq[m_pos];
      end
   endfunction

   task automatic tick();
      int eg;
      model_step();
      @(posedge clk);
      #1;
      eg = (m_owner < 0) ? 0 : (1 << m_owner);
      chk("model_grant", int'(grant), eg);
      chk("model_done", int'(done), m_done ? eg : 0);
      chk("model_count", int'(count), m_count);
      chk("model_busy", int'(busy), (m_owner >= 0) ? 1 : 0);
      chk("grant_onehot", ($countones(grant) <= 1) ? 1 : 0, 1);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_reset();
      @(negedge clk);
      reset = 1'b1;
   endtask

   typedef struct {
      logic [NREQ-1:0]       req;
      logic [NREQ-1:0]       ud;
      logic [NREQ*WIDTH-1:0] lim;
      logic [NREQ-1:0]       g;
      logic [NREQ-1:0]       d;
      logic [WIDTH-1:0]      c;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [3:0] r, input logic [3:0] u, input logic [15:0] l,
                      input logic [3:0] g, input logic [3:0] d, input logic [3:0] c);
      vec_t v;
      v.req = r; v.ud = u; v.lim = l; v.g = g; v.d = d; v.c = c;
      tbl.push_back(v);
   endtask

   int order[$];
   int runlen[$];
   int exp_order[5];
   int len;
   int maxc;
   bit seen_done;
   logic [NREQ-1:0] prev_g;

   initial begin
      reset = 1'b0;
      req   = '0;
      up_dn = '0;
      limit = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_grant", int'(grant), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_count", int'(count), 0);
      chk("reset_done", int'(done), 0);
      @(negedge clk);
      reset = 1'b1;

      // Up run of requester 0 to 5, then down run of requester 1 from 3.
      add(4'b0001, 4'b0001, 16'h0005, 4'b0001, 4'b0000, 4'd0);
      for (int i = 1; i <= 5; i++) add(4'b0001, 4'b0001, 16'h0005, 4'b0001, 4'b0000, 4'(i));
      add(4'b0001, 4'b0001, 16'h0005, 4'b0001, 4'b0001, 4'd5);
      add(4'b0000, 4'b0001, 16'h0005, 4'b0000, 4'b0000, 4'd5);
      add(4'b0000, 4'b0001, 16'h0005, 4'b0000, 4'b0000, 4'd5);
      for (int i = 3; i >= 0; i--) add(4'b0010, 4'b0000, 16'h0030, 4'b0010, 4'b0000, 4'(i));
      add(4'b0010, 4'b0000, 16'h0030, 4'b0010, 4'b0010, 4'd0);
      add(4'b0000, 4'b0000, 16'h0030, 4'b0000, 4'b0000, 4'd0);
      foreach (tbl[i]) begin
         req   = tbl[i].req;
         up_dn = tbl[i].ud;
         limit = tbl[i].lim;
         tick();
         chk($sformatf("vec%0d_grant", i), int'(grant), int'(tbl[i].g));
         chk($sformatf("vec%0d_done", i), int'(done), int'(tbl[i].d));
         chk($sformatf("vec%0d_count", i), int'(count), int'(tbl[i].c));
      end

      // Round-robin rotation with all requesters held.
      do_reset();
      req   = 4'b1111;
      up_dn = 4'b1111;
      limit = 16'h1111;
      prev_g = '0;
      len = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (grant != '0 && grant != prev_g) order.push_back(int'(grant));
         if (grant != '0) len++;
         else if (prev_g != '0) begin
            runlen.push_back(len);
            len = 0;
         end
         prev_g = grant;
      end
      exp_order = '{1, 2, 4, 8, 1};
      chk("rr_order_len", (order.size() >= 5) ? 1 : 0, 1);
      for (int i = 0; i < 5 && i < order.size(); i++)
         chk($sformatf("rr_order%0d", i), order[i], exp_order[i]);
      chk("rr_runs_len", (runlen.size() >= 4) ? 1 : 0, 1);
      for (int i = 0; i < 4 && i < runlen.size(); i++)
         chk($sformatf("rr_runlen%0d", i), runlen[i], 3);
      req = '0;
      repeat (4) tick();

      // Abort: drop req[2] when count reaches 2.
      req   = 4'b0100;
      up_dn = 4'b0100;
      limit = 16'h0900;
      for (int i = 0; i < 20 && !(grant == 4'b0100 && count == 4'd2); i++) tick();
      chk("abort_reach2", int'(count), 2);
      req = '0;
      tick();
      chk("abort_grant", int'(grant), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_count", int'(count), 2);
      tick();

      // Asynchronous reset mid-run, then 1010 must go to requester 1 first.
      req   = 4'b0001;
      up_dn = 4'b0001;
      limit = 16'h0009;
      for (int i = 0; i < 20 && !(grant == 4'b0001 && count == 4'd4); i++) tick();
      chk("rst_reach4", int'(count), 4);
      #2;
      reset = 1'b0;
      #1;
      chk("rst_async_grant", int'(grant), 0);
      chk("rst_async_busy", int'(busy), 0);
      chk("rst_async_count", int'(count), 0);
      chk("rst_async_done", int'(done), 0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      req = 4'b1010;
      tick();
      chk("rst_first_grant", int'(grant), 2);
      req = '0;
      repeat (8) tick();

      // limit 0 both directions, then full-scale up run.
      for (int dir = 1; dir >= 0; dir--) begin
         req   = 4'b0001;
         up_dn = 4'(dir);
         limit = 16'h0000;
         tick();
         chk("lim0_grant", int'(grant), 1);
         chk("lim0_count_run", int'(count), 0);
         tick();
         chk("lim0_done", int'(done), 1);
         chk("lim0_count_done", int'(count), 0);
         req = '0;
         tick();
         chk("lim0_idle", int'(grant), 0);
      end
      req   = 4'b0001;
      up_dn = 4'b0001;
      limit = 16'h000f;
      maxc = 0;
      seen_done = 1'b0;
      for (int i = 0; i < 40 && !seen_done; i++) begin
         tick();
         if (int'(count) > maxc) maxc = int'(count);
         if (done != '0) seen_done = 1'b1;
      end
      chk("lim15_done_seen", int'(seen_done), 1);
      chk("lim15_max", maxc, 15);
      chk("lim15_final", int'(count), 15);
      req = '0;
      tick();

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) req = 4'($urandom);
         if ($urandom_range(0, 3) == 0) up_dn = 4'($urandom);
         if ($urandom_range(0, 3) == 0) limit = 16'($urandom);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
